// File: rtl/decode_stage.sv
// decode_stage: splits the fetched word into execute fields, one cycle of latency.
// Define DECODE_SCOREBOARD_EN to add the pending-write table, hold register and RAW stall.
module decode_stage #(
    parameter int unsigned PENDING_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instructionDecode,
    output logic        stall,
    output logic        valid_ex,
    output logic [4:0]  opc_ex,
    output logic [3:0]  rc_ex,
    output logic [3:0]  ra_ex,
    output logic [3:0]  rb_ex,
    output logic        imb_ex,
    output logic [2:0]  cond_ex,
    output logic        cmp_ex,
    output logic [13:0] imm_ex
);

    logic [31:0] sel;
    logic        hazard;

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] hold;
    logic        hold_valid;
    logic        pend_v [PENDING_DEPTH];
    logic [3:0]  pend_r [PENDING_DEPTH];

    logic [4:0]  sel_opc;
    logic [3:0]  sel_rc;
    logic [3:0]  sel_ra;
    logic [3:0]  sel_rb;
    logic        sel_imb;
    logic        sel_writes;
    logic        rd_a;
    logic        rd_b;

    assign sel     = hold_valid ? hold : instructionDecode;
    assign sel_opc = sel[31:27];
    assign sel_rc  = sel[26:23];
    assign sel_ra  = sel[22:19];
    assign sel_imb = sel[18];
    assign sel_rb  = sel[3:0];

    // Opcodes 1..15 write Rc; R0 is never tracked and never read-hazards.
    assign sel_writes = (sel_opc != 5'd0) && !sel_opc[4] && (sel_rc != 4'd0);
    assign rd_a       = (sel_opc != 5'd0) && (sel_ra != 4'd0);
    assign rd_b       = (sel_opc != 5'd0) && !sel_imb && (sel_rb != 4'd0);

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < PENDING_DEPTH; i++) begin
            if (pend_v[i] && ((rd_a && (sel_ra == pend_r[i])) ||
                              (rd_b && (sel_rb == pend_r[i]))))
                hazard = 1'b1;
        end
    end

    // Qualified by rst so stall stays low for the whole reset window.
    assign stall = hazard && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            for (int unsigned i = 0; i < PENDING_DEPTH; i++) begin
                pend_v[i] <= 1'b0;
                pend_r[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < PENDING_DEPTH; i++) begin
                pend_v[i] <= pend_v[i-1];
                pend_r[i] <= pend_r[i-1];
            end
            pend_v[0]  <= sel_writes && !hazard;
            pend_r[0]  <= sel_rc;
            hold_valid <= hazard;
            if (hazard)
                hold <= sel;
        end
    end
`else
    assign sel    = instructionDecode;
    assign hazard = 1'b0;
    assign stall  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst || hazard) begin
            valid_ex <= 1'b0;
            opc_ex   <= '0;
            rc_ex    <= '0;
            ra_ex    <= '0;
            rb_ex    <= '0;
            imb_ex   <= 1'b0;
            cond_ex  <= '0;
            cmp_ex   <= 1'b0;
            imm_ex   <= '0;
        end else begin
            valid_ex <= (sel[31:27] != 5'd0);
            opc_ex   <= sel[31:27];
            rc_ex    <= sel[26:23];
            ra_ex    <= sel[22:19];
            rb_ex    <= sel[3:0];
            imb_ex   <= sel[18];
            cond_ex  <= sel[17:15];
            cmp_ex   <= sel[14];
            imm_ex   <= sel[13:0];
        end
    end

endmodule
